branch_predictor: RTL and testbench
===================================

# branch_predictor

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Each cycle it looks up the IF-stage pc and drives the predicted target and PC-select code into the PC register.
- It takes branch resolution from EXE, detects mispredictions, issues the EXE recovery select and flush, and updates the table.
- It is the producer side of the PCSel / Predict_Target_pc interface that the PC register consumes.

## Interface
Parameters:
- addrWidth, 16, pc width in bits.
- ENTRIES, 16, number of BTB entries; must be a power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Stall  input  1  pipeline stall; blocks table and counter updates.
- Hcf  input  1  halt; blocks table and counter updates.
- IF_pc  input  addrWidth  fetch pc to look up.
- EXE_valid  input  1  EXE stage holds a live instruction.
- EXE_is_branch  input  1  EXE instruction is a conditional branch or jump.
- EXE_taken  input  1  resolved direction.
- EXE_pc  input  addrWidth  pc of the EXE instruction.
- EXE_Target_pc  input  addrWidth  resolved target.
- EXE_pred_taken  input  1  prediction bit carried down the pipeline from IF.
- EXE_pred_target  input  addrWidth  predicted target carried down the pipeline from IF.
- PCSel  output  2  next-pc select code.
- Predict_Target_pc  output  addrWidth  BTB target for IF_pc.
- IF_pred_taken  output  1  prediction for IF_pc; pipeline carries it to EXE.
- Flush  output  1  kill the IF and ID instructions.
- Branch_cnt  output  32  number of branch/jump updates performed.
- Mispredict_cnt  output  32  number of mispredictions.

## Operation
Entry layout:
- Each entry holds valid, tag, target[addrWidth-1:0] and ctr[1:0].
- Index = pc[IDX_W+1:2]; tag = pc[addrWidth-1:IDX_W+2].

Lookup (combinational):
- hit = valid && tag match on IF_pc.
- IF_pred_taken = hit && ctr[1].
- Predict_Target_pc = entry target when hit, else 0.

Mispredict (combinational), mis = EXE_valid && one of:
- EXE_is_branch and EXE_taken != EXE_pred_taken;
- EXE_is_branch and both taken and EXE_pred_target != EXE_Target_pc;
- !EXE_is_branch and EXE_pred_taken (table alias on a non-branch).

PCSel priority:
- mis and actual taken: `EXE_T_PC`.
- mis and actual not taken (including non-branch alias): `EXE_PC_PLUS_4`.
- else IF_pred_taken: `IF_P_T_PC`.
- else `IF_PC_PLUS_4`.
- Flush = mis.

Update, only when EXE_valid && !Stall && !Hcf:
- Taken branch, entry hit: target written, ctr incremented, saturating at 11.
- Taken branch, entry miss: allocate with valid=1, tag, target, ctr=10 (replaces any previous occupant).
- Not-taken branch, entry hit: ctr decremented, saturating at 00; entry stays valid.
- Not-taken branch, entry miss: no change.
- Non-branch with EXE_pred_taken=1: entry at EXE_pc index invalidated if its tag matches.
- Branch_cnt increments on every branch update; Mispredict_cnt increments when mis and the update is enabled. Both wrap modulo 2^32.

## Timing
- Lookup latency is 0 cycles: the prediction is valid in the same cycle as IF_pc.
- A table update is visible to lookup from the next cycle.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents.
- Stall or Hcf blocks updates but not the combinational outputs. PCSel/Flush still reflect mis; the PC register ignores them while held.
- Reset values: every valid=0, every ctr=01, every target=0, Branch_cnt=0, Mispredict_cnt=0.
- Consequences of reset: PCSel=`IF_PC_PLUS_4`, Predict_Target_pc=0, IF_pred_taken=0; Flush=0 while EXE inputs are idle.
- Reset asserted mid-update discards that update.

## Configuration
- BP_PERF_CNT_EN defined: Branch_cnt and Mispredict_cnt registers are built as described.
- BP_PERF_CNT_EN undefined: the counter registers are absent and both outputs are tied to 32'd0. Prediction behaviour is identical either way.

## Structure
- PCSel codes live in rv32_define.v next to the existing PC constants: `IF_PC_PLUS_4`=2'b00, `IF_P_T_PC`=2'b01, `EXE_PC_PLUS_4`=2'b10, `EXE_T_PC`=2'b11.
- Counter state constants go there as well: `BP_SNT`=00, `BP_WNT`=01, `BP_WT`=10, `BP_ST`=11.
- One sub-module: bp_sat_counter, the 2-bit saturating inc/dec next-state function. Instantiated once on the update path.

## Test plan
- Reset, then IF_pc=0x0040 -> PCSel=00, IF_pred_taken=0, Predict_Target_pc=0.
- EXE: taken branch at 0x0040, target 0x0100, pred_taken=0 -> same cycle PCSel=11, Flush=1. Next cycle IF_pc=0x0040 -> PCSel=01, Predict_Target_pc=0x0100.
- Same branch taken three more times -> ctr saturates at 11. Two not-taken resolutions -> ctr 01, IF_pred_taken=0. The not-taken resolution made with pred_taken=1 gives PCSel=10, Flush=1.
- Target change: taken to 0x0200 while EXE_pred_target=0x0100 -> PCSel=11, entry target becomes 0x0200.
- Stall=1 during a mispredicting EXE -> PCSel=11 still driven, table and Mispredict_cnt unchanged.
- Alias: entries 0x0040 and 0x0080 (16 entries) share an index; allocating 0x0080 evicts 0x0040. Then 0x0040 misses -> PCSel=00. A non-branch at 0x0080 with pred_taken=1 -> PCSel=10 and the entry is invalidated.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: PC-select codes and 2-bit counter states shared by the predictor.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        IF_PC_PLUS_4  = 2'b00,
        IF_P_T_PC     = 2'b01,
        EXE_PC_PLUS_4 = 2'b10,
        EXE_T_PC      = 2'b11
    } pcsel_e;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next state of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_inc ? ((i_ctr == BP_ST)  ? BP_ST  : i_ctr + 2'd1)
                      : ((i_ctr == BP_SNT) ? BP_SNT : i_ctr - 2'd1);
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, EXE mispredict recovery and table update.
// Define BP_PERF_CNT_EN to build the Branch_cnt / Mispredict_cnt registers; otherwise both read 0.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int addrWidth = 16,
    parameter int ENTRIES   = 16,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Stall,
    input  logic                 Hcf,
    input  logic [addrWidth-1:0] IF_pc,
    input  logic                 EXE_valid,
    input  logic                 EXE_is_branch,
    input  logic                 EXE_taken,
    input  logic [addrWidth-1:0] EXE_pc,
    input  logic [addrWidth-1:0] EXE_Target_pc,
    input  logic                 EXE_pred_taken,
    input  logic [addrWidth-1:0] EXE_pred_target,
    output logic [1:0]           PCSel,
    output logic [addrWidth-1:0] Predict_Target_pc,
    output logic                 IF_pred_taken,
    output logic                 Flush,
    output logic [31:0]          Branch_cnt,
    output logic [31:0]          Mispredict_cnt
);

    localparam int TAG_W = addrWidth - IDX_W - 2;

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [addrWidth-1:0] r_target [ENTRIES];
    logic [1:0]           r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    logic             w_if_hit, w_ex_hit, w_mis, w_upd;
    logic [1:0]       w_ctr_nxt;
    logic             w_unused;

    assign w_if_idx = IF_pc[IDX_W+1:2];
    assign w_if_tag = IF_pc[addrWidth-1:IDX_W+2];
    assign w_ex_idx = EXE_pc[IDX_W+1:2];
    assign w_ex_tag = EXE_pc[addrWidth-1:IDX_W+2];
    assign w_unused = ^{IF_pc[1:0], EXE_pc[1:0]};

    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd    = EXE_valid && !Stall && !Hcf;

    // A non-branch predicted taken means the table aliased it onto a branch entry.
    always_comb begin
        w_mis = EXE_valid && (EXE_is_branch
                ? ((EXE_taken != EXE_pred_taken) || (EXE_taken && (EXE_pred_target != EXE_Target_pc)))
                : EXE_pred_taken);
        IF_pred_taken     = w_if_hit && r_ctr[w_if_idx][1];
        Predict_Target_pc = w_if_hit ? r_target[w_if_idx] : '0;
        PCSel = w_mis ? ((EXE_is_branch && EXE_taken) ? EXE_T_PC : EXE_PC_PLUS_4)
                      : (IF_pred_taken ? IF_P_T_PC : IF_PC_PLUS_4);
        Flush = w_mis;
    end

    bp_sat_counter u_sat (
        .i_ctr (r_ctr[w_ex_idx]),
        .i_inc (EXE_taken),
        .o_ctr (w_ctr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= BP_WNT;
            end
        end else if (w_upd && EXE_is_branch) begin
            if (EXE_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= EXE_Target_pc;
                r_ctr[w_ex_idx]    <= w_ex_hit ? w_ctr_nxt : BP_WT;
            end else if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_nxt;
            end
        end else if (w_upd && EXE_pred_taken && (r_tag[w_ex_idx] == w_ex_tag)) begin
            r_valid[w_ex_idx] <= 1'b0;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_branch_cnt, r_mis_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else begin
            if (w_upd && EXE_is_branch) r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_upd && w_mis)         r_mis_cnt    <= r_mis_cnt + 32'd1;
        end
    end

    assign Branch_cnt     = r_branch_cnt;
    assign Mispredict_cnt = r_mis_cnt;
`else
    assign Branch_cnt     = 32'd0;
    assign Mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, reset corner cases, and random stimulus against a table model.
module tb_branch_predictor;

    logic        clk = 0, rst = 1, Stall = 0, Hcf = 0;
    logic        EXE_valid = 0, EXE_is_branch = 0, EXE_taken = 0, EXE_pred_taken = 0;
    logic [15:0] IF_pc = 0, EXE_pc = 0, EXE_Target_pc = 0, EXE_pred_target = 0;
    logic [1:0]  PCSel;
    logic [15:0] Predict_Target_pc;
    logic        IF_pred_taken, Flush;
    logic [31:0] Branch_cnt, Mispredict_cnt;

    int checks = 0, errors = 0;

`ifdef BP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Hcf(Hcf), .IF_pc(IF_pc),
        .EXE_valid(EXE_valid), .EXE_is_branch(EXE_is_branch), .EXE_taken(EXE_taken),
        .EXE_pc(EXE_pc), .EXE_Target_pc(EXE_Target_pc), .EXE_pred_taken(EXE_pred_taken),
        .EXE_pred_target(EXE_pred_target), .PCSel(PCSel), .Predict_Target_pc(Predict_Target_pc),
        .IF_pred_taken(IF_pred_taken), .Flush(Flush), .Branch_cnt(Branch_cnt),
        .Mispredict_cnt(Mispredict_cnt)
    );

    typedef struct {
        logic [15:0] ifpc;
        logic        v, br, tk;
        logic [15:0] epc, etgt;
        logic        pt;
        logic [15:0] ptgt;
        logic        st, hc;
        logic [1:0]  sel;
        logic [15:0] tgt;
        logic        ipt, fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [15:0] ifpc, input logic v, br, tk,
                                input logic [15:0] epc, etgt, input logic pt,
                                input logic [15:0] ptgt, input logic st, hc,
                                input logic [1:0] sel, input logic [15:0] tgt, input logic ipt, fl);
        vec_t r;
        r.ifpc = ifpc; r.v = v; r.br = br; r.tk = tk; r.epc = epc; r.etgt = etgt;
        r.pt = pt; r.ptgt = ptgt; r.st = st; r.hc = hc;
        r.sel = sel; r.tgt = tgt; r.ipt = ipt; r.fl = fl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        IF_pc = t.ifpc; EXE_valid = t.v; EXE_is_branch = t.br; EXE_taken = t.tk;
        EXE_pc = t.epc; EXE_Target_pc = t.etgt; EXE_pred_taken = t.pt;
        EXE_pred_target = t.ptgt; Stall = t.st; Hcf = t.hc;
    endtask

    task automatic idle_exe();
        EXE_valid = 0; EXE_is_branch = 0; EXE_taken = 0; EXE_pred_taken = 0;
        EXE_pc = 0; EXE_Target_pc = 0; EXE_pred_target = 0; Stall = 0; Hcf = 0;
    endtask

    // Reference model: plain arrays indexed by word address modulo 16, counters as 0..3.
    bit          m_valid[16];
    int          m_tag[16], m_tgt[16], m_ctr[16];
    int unsigned m_bcnt, m_mcnt;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bcnt = 0; m_mcnt = 0;
    endfunction

    function automatic int idx_of(input logic [15:0] pc); return (int'(pc) / 4) % 16; endfunction
    function automatic int tag_of(input logic [15:0] pc); return int'(pc) / 64; endfunction

    function automatic bit m_mis();
        if (!EXE_valid) return 0;
        if (!EXE_is_branch) return EXE_pred_taken;
        return (EXE_taken != EXE_pred_taken) || (EXE_taken && EXE_pred_target != EXE_Target_pc);
    endfunction

    task automatic m_check(input string tag);
        int  i = idx_of(IF_pc);
        bit  hit = m_valid[i] && m_tag[i] == tag_of(IF_pc);
        bit  ipt = hit && m_ctr[i] >= 2;
        bit  mis = m_mis();
        int  sel = mis ? ((EXE_is_branch && EXE_taken) ? 3 : 2) : (ipt ? 1 : 0);
        chk({tag, " PCSel"}, 32'(PCSel), 32'(sel));
        chk({tag, " target"}, 32'(Predict_Target_pc), hit ? 32'(m_tgt[i]) : 32'd0);
        chk({tag, " pred"}, 32'(IF_pred_taken), 32'(ipt));
        chk({tag, " flush"}, 32'(Flush), 32'(mis));
        chk({tag, " bcnt"}, Branch_cnt, PERF ? m_bcnt : 32'd0);
        chk({tag, " mcnt"}, Mispredict_cnt, PERF ? m_mcnt : 32'd0);
    endtask

    task automatic m_update();
        int j = idx_of(EXE_pc);
        int tg = tag_of(EXE_pc);
        bit hit = m_valid[j] && m_tag[j] == tg;
        if (!EXE_valid || Stall || Hcf) return;
        if (m_mis()) m_mcnt++;
        if (EXE_is_branch) begin
            m_bcnt++;
            if (EXE_taken) begin
                m_ctr[j] = hit ? (m_ctr[j] == 3 ? 3 : m_ctr[j] + 1) : 2;
                m_valid[j] = 1; m_tag[j] = tg; m_tgt[j] = int'(EXE_Target_pc);
            end else if (hit) begin
                m_ctr[j] = m_ctr[j] == 0 ? 0 : m_ctr[j] - 1;
            end
        end else if (EXE_pred_taken && m_tag[j] == tg) begin
            m_valid[j] = 0;
        end
    endtask

    function automatic logic [15:0] rpc();
        return 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd0, 16'h000, 0,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h100, 0, 16'h000, 0,0, 2'd3, 16'h000, 0,1));
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd1, 16'h100, 1,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h100, 1, 16'h100, 0,0, 2'd1, 16'h100, 1,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h100, 1, 16'h100, 0,0, 2'd1, 16'h100, 1,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h100, 1, 16'h100, 0,0, 2'd1, 16'h100, 1,0));
        tbl.push_back(mk(16'h40, 1,1,0, 16'h40, 16'h100, 1, 16'h100, 0,0, 2'd2, 16'h100, 1,1));
        tbl.push_back(mk(16'h40, 1,1,0, 16'h40, 16'h100, 1, 16'h100, 0,0, 2'd2, 16'h100, 1,1));
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd0, 16'h100, 0,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h200, 1, 16'h100, 0,0, 2'd3, 16'h100, 0,1));
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd1, 16'h200, 1,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h40, 16'h300, 0, 16'h000, 1,0, 2'd3, 16'h200, 1,1));
        tbl.push_back(mk(16'h40, 1,1,0, 16'h40, 16'h200, 1, 16'h200, 0,1, 2'd2, 16'h200, 1,1));
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd1, 16'h200, 1,0));
        tbl.push_back(mk(16'h40, 1,1,1, 16'h80, 16'h400, 0, 16'h000, 0,0, 2'd3, 16'h200, 1,1));
        tbl.push_back(mk(16'h40, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd0, 16'h000, 0,0));
        tbl.push_back(mk(16'h80, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd1, 16'h400, 1,0));
        tbl.push_back(mk(16'h80, 1,0,0, 16'h80, 16'h000, 1, 16'h000, 0,0, 2'd2, 16'h400, 1,1));
        tbl.push_back(mk(16'h80, 0,0,0, 16'h00, 16'h000, 0, 16'h000, 0,0, 2'd0, 16'h000, 0,0));

        repeat (2) @(negedge clk);
        rst = 0;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k]);
            #1;
            chk($sformatf("vec%0d PCSel", k), 32'(PCSel), 32'(tbl[k].sel));
            chk($sformatf("vec%0d target", k), 32'(Predict_Target_pc), 32'(tbl[k].tgt));
            chk($sformatf("vec%0d pred", k), 32'(IF_pred_taken), 32'(tbl[k].ipt));
            chk($sformatf("vec%0d flush", k), 32'(Flush), 32'(tbl[k].fl));
        end
        chk("table bcnt", Branch_cnt, PERF ? 32'd8 : 32'd0);
        chk("table mcnt", Mispredict_cnt, PERF ? 32'd6 : 32'd0);

        // Reset raised while a taken-branch allocation is presented: the allocation must be lost.
        @(negedge clk);
        IF_pc = 16'h44; EXE_valid = 1; EXE_is_branch = 1; EXE_taken = 1;
        EXE_pc = 16'h44; EXE_Target_pc = 16'h500; EXE_pred_taken = 0; EXE_pred_target = 0;
        #2 rst = 1;
        @(negedge clk);
        idle_exe();
        rst = 0;
        #1;
        chk("rst-mid PCSel", 32'(PCSel), 32'd0);
        chk("rst-mid target", 32'(Predict_Target_pc), 32'd0);
        chk("rst-mid pred", 32'(IF_pred_taken), 32'd0);
        chk("rst-mid bcnt", Branch_cnt, 32'd0);
        chk("rst-mid mcnt", Mispredict_cnt, 32'd0);
        IF_pc = 16'h80;
        #1;
        chk("rst-clear 0x80", 32'(Predict_Target_pc), 32'd0);

        m_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            IF_pc = rpc();
            EXE_pc = rpc();
            EXE_valid = $urandom_range(0, 7) != 0;
            EXE_is_branch = $urandom_range(0, 3) != 0;
            EXE_taken = $urandom_range(0, 1);
            EXE_pred_taken = $urandom_range(0, 1);
            EXE_Target_pc = 16'($urandom_range(1, 3) << 8);
            EXE_pred_target = $urandom_range(0, 1) ? 16'(m_tgt[idx_of(EXE_pc)])
                                                   : 16'($urandom_range(1, 3) << 8);
            Stall = $urandom_range(0, 9) == 0;
            Hcf = $urandom_range(0, 19) == 0;
            #1;
            m_check($sformatf("rnd%0d", n));
            m_update();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
